rgb2gray_stream: RTL



---
 rtl/rgb2gray_pkg.sv | 26 ++
 rtl/rgb2gray_mac.sv | 70 +++++++
 rtl/rgb2gray_stream.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rgb2gray_pkg.sv
`default_nettype none
// ============================================================================
// Module : rgb2gray_pkg
// Brief  : Shared types, default luma weights and width helpers for rgb2gray.
// Rev    : 1.0
// ============================================================================
package rgb2gray_pkg;

    // Fixed-point weights 77/150/29 (sum 256), ch0 in the LSBs.
    localparam logic [23:0] LUMA_COEFS = {8'd29, 8'd150, 8'd77};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    function automatic int acc_width(input int data_w, input int coef_w, input int num_ch);
        return data_w + coef_w + $clog2(num_ch);
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb2gray_mac.sv
`default_nettype none
// ============================================================================
// Module : rgb2gray_mac
// Brief  : Per-beat weighted/max accumulator with round-and-saturate result.
// Rev    : 1.0
// ============================================================================
module rgb2gray_mac
    import rgb2gray_pkg::*;
#(
    parameter int                         DATA_W = 8,
    parameter int                         NUM_CH = 3,
    parameter int                         COEF_W = 8,
    parameter logic [NUM_CH*COEF_W-1:0]   COEFS  = LUMA_COEFS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  logic                          i_first,
    input  logic                          i_mode,
    input  logic [ch_width(NUM_CH)-1:0]   i_ch,
    input  logic [DATA_W-1:0]             i_data,
    output logic [DATA_W-1:0]             o_result
);

    localparam int               c_acc_w  = acc_width(DATA_W, COEF_W, NUM_CH);
    localparam int               c_prod_w = DATA_W + COEF_W;
    localparam logic [c_acc_w:0] c_half   = {{c_acc_w{1'b0}}, 1'b1} << (COEF_W - 1);

    logic [c_acc_w-1:0]  r_acc;
    logic [c_acc_w-1:0]  w_base;
    logic [c_acc_w-1:0]  w_sample;
    logic [c_acc_w-1:0]  w_acc_next;
    logic [COEF_W-1:0]   w_coef;
    logic [c_prod_w-1:0] w_prod;
    logic [c_acc_w:0]    w_rounded;
    logic [c_acc_w:0]    w_shifted;

    // The result is derived from the next accumulator value so the output
    // register can capture it on the same edge as the final beat.
    always_comb begin
        w_coef     = COEFS[int'(i_ch)*COEF_W +: COEF_W];
        w_prod     = {{DATA_W{1'b0}}, w_coef} * {{COEF_W{1'b0}}, i_data};
        w_sample   = c_acc_w'(i_data);
        w_base     = i_first ? '0 : r_acc;
        if (i_mode) begin
            w_acc_next = (w_sample > w_base) ? w_sample : w_base;
        end else begin
            w_acc_next = w_base + c_acc_w'(w_prod);
        end
        w_rounded  = {1'b0, w_acc_next} + c_half;
        w_shifted  = w_rounded >> COEF_W;
        if (i_mode) begin
            o_result = w_acc_next[DATA_W-1:0];
        end else if (|w_shifted[c_acc_w:DATA_W]) begin
            o_result = '1;
        end else begin
            o_result = w_shifted[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb2gray_stream.sv
`default_nettype none
// ============================================================================
// Module : rgb2gray_stream
// Brief  : Streaming per-channel colour to grayscale converter (valid/ready).
// Rev    : 1.0
// ============================================================================
module rgb2gray_stream
    import rgb2gray_pkg::*;
#(
    parameter int                         DATA_W = 8,
    parameter int                         NUM_CH = 3,
    parameter int                         COEF_W = 8,
    parameter logic [NUM_CH*COEF_W-1:0]   COEFS  = LUMA_COEFS
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          mode_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          in_sop_i,
    input  logic [DATA_W-1:0]             in_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_W-1:0]             out_data_o,
    output logic                          err_o
);

    localparam int                c_ch_w    = ch_width(NUM_CH);
    localparam logic [c_ch_w-1:0] c_last_ch = c_ch_w'(NUM_CH - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_ch_w-1:0]   r_ch_cnt;
    logic [c_ch_w-1:0]   w_ch_cnt_next;
    logic [c_ch_w-1:0]   w_ch;
    logic                r_mode;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_err;
    logic [DATA_W-1:0]   w_result;
    logic                w_accept;
    logic                w_start;
    logic                w_cont;
    logic                w_drop;
    logic                w_last;
    logic                w_mode;

    assign in_ready_o = !(r_out_valid && !out_ready_i);
    assign w_accept   = in_valid_i && in_ready_o;
    // A sop beat always opens a new pixel, abandoning any partial one.
    assign w_start    = w_accept && in_sop_i;
    assign w_cont     = w_accept && !in_sop_i && (r_state == ACC);
    assign w_drop     = w_accept && !in_sop_i && (r_state == IDLE);
    assign w_ch       = w_start ? '0 : r_ch_cnt;
    assign w_mode     = w_start ? mode_i : r_mode;
    assign w_last     = (w_start && (NUM_CH == 1)) || (w_cont && (r_ch_cnt == c_last_ch));

    rgb2gray_mac #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .COEF_W (COEF_W),
        .COEFS  (COEFS)
    ) u_mac (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_en     (w_start || w_cont),
        .i_first  (w_start),
        .i_mode   (w_mode),
        .i_ch     (w_ch),
        .i_data   (in_data_i),
        .o_result (w_result)
    );

    always_comb begin
        w_state_next  = r_state;
        w_ch_cnt_next = r_ch_cnt;
        if (w_start) begin
            if (NUM_CH == 1) begin
                w_state_next  = IDLE;
                w_ch_cnt_next = '0;
            end else begin
                w_state_next  = ACC;
                w_ch_cnt_next = c_ch_w'(1);
            end
        end else if (w_cont) begin
            if (w_last) begin
                w_state_next  = IDLE;
                w_ch_cnt_next = '0;
            end else begin
                w_ch_cnt_next = r_ch_cnt + c_ch_w'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_ch_cnt    <= '0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ch_cnt <= w_ch_cnt_next;
            if (w_start) begin
                r_mode <= mode_i;
            end
            if (w_last) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
            if ((w_start && (r_state == ACC)) || w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign err_o       = r_err;

endmodule
`default_nettype wire
